multi_master_bus: RTL and testbench
===================================

# multi_master_bus

Parametrised shared-bus controller for up to MASTERS requesters over a single internal tri-state data bus. Generalises the two-requester fixed-priority tri-state bus: configurable width and master count, fixed-priority or round-robin arbitration, and a bounded bus tenure that forces hand-over when other masters are waiting. Sits between peripheral masters and any shared consumer, broadcasting the owner's word on a registered output with a valid flag.

## Interface
- WIDTH, 8, data word width (≥1)
- MASTERS, 4, number of requesters (2..16)
- MODE, 0, arbitration: 0 = fixed priority (index 0 highest), 1 = round-robin
- MAX_HOLD, 4, maximum consecutive owner cycles while another master requests; 0 = unlimited
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  MASTERS  request per master, level-sensitive
- data_in  in  MASTERS*WIDTH  master i word at [i*WIDTH +: WIDTH]
- gnt  out  MASTERS  registered one-hot grant, all-zero when idle
- bus_owner  out  max(1,$clog2(MASTERS))  index of granted master; holds last owner when idle
- bus_valid  out  1  data_out carries a granted word this cycle
- data_out  out  WIDTH  registered copy of bi_data, broadcast to all masters

## Operation
- Internal bi_data: WIDTH-bit tri-state net; master i drives data_in[i] only when gnt[i]=1, else 'z. Never more than one driver.
- FSM states IDLE, BUSY.
- IDLE: no req -> stay, gnt=0. Any req -> BUSY, gnt = arbitration winner.
- BUSY, owner req high, tenure not expired -> keep owner, tenure++.
- BUSY, owner req low -> re-arbitrate among remaining requesters in the same edge; winner granted, tenure=0; none -> IDLE, gnt=0.
- Tenure expiry: MAX_HOLD≠0, tenure = MAX_HOLD-1, another req high -> owner excluded from that arbitration, winner granted, tenure=0. Owner may re-win later. No other requester -> owner keeps bus, tenure saturates.
- Fixed mode: lowest requesting index wins (subject to exclusion).
- Round-robin mode: search starts at rr_ptr, wraps MASTERS-1 -> 0; on every grant rr_ptr = winner+1 mod MASTERS.
- data_out <= bi_data when any gnt bit set, else holds previous value; bus_valid <= |gnt.

## Timing
- Reset values: gnt=0, bus_owner=0, bus_valid=0, data_out=0, state IDLE, tenure=0, rr_ptr=0. Reset mid-burst drops grant immediately (asynchronously); first grant possible at first edge after rst deasserts.
- req sampled at edge k -> gnt/bus_owner valid after edge k -> data_out/bus_valid reflect data_in[owner] after edge k+1. Fixed 2-cycle request-to-data latency.
- Hand-over is back-to-back: no idle cycle between owners; bus_valid stays high.
- data_in changes during tenure appear on data_out one edge later.
- Owner dropping req: one trailing bus_valid cycle with its last word.
- Simultaneous new requests at same edge resolved by MODE; ties never produce multi-hot gnt.

## Structure
- Package bus_pkg: FSM state enum (IDLE, BUSY), MODE constants (ARB_FIXED=0, ARB_RR=1), clog2 helper.
- Sub-module bus_arbiter: combinational pick from req mask, exclusion mask and start pointer -> one-hot winner plus index; top holds FSM, tenure counter, rr_ptr, tri-state drivers and output registers.

## Test plan
- Reset: rst=1 with req=4'b1111 -> gnt=0, bus_valid=0, data_out=8'h00; deassert -> gnt=4'b0001 one edge later (MODE=0).
- Fixed priority: req=4'b0110, data_in[1]=8'hAA, data_in[2]=8'h55 -> gnt=4'b0010, data_out=8'hAA; drop req[1] -> gnt=4'b0100 next edge, data_out=8'h55 edge after, bus_valid never low.
- Round-robin: MODE=1, MAX_HOLD=1, req=4'b1111 held -> bus_owner sequence 0,1,2,3,0 on consecutive edges.
- Tenure limit: MAX_HOLD=4, req[0] high, req[3] raised after 1 cycle -> master 0 owns 4 cycles, then gnt=4'b1000; with req[3] low master 0 keeps bus indefinitely.
- Idle/hold: all req drop while data_out=8'hE5 -> gnt=0, bus_valid=0 after next edge, data_out stays 8'hE5.
- Async reset mid-burst: rst pulse between edges while gnt=4'b0100 -> gnt=0 and data_out=0 immediately, no edge required.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared definitions for the multi-master tri-state bus controller:
// FSM state encoding, arbitration mode constants and an index-width helper.
package bus_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Width needed to hold an index in 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        if (n > 1) begin
            return $clog2(n);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/multi_master_bus_if.sv
// Bus bundle between the requesting masters and the bus controller.
// The master modport is the requester side; the slave modport is the controller.
interface multi_master_bus_if #(
    parameter int WIDTH   = 8,
    parameter int MASTERS = 4
);
    localparam int IW = bus_pkg::idx_width(MASTERS);

    logic [MASTERS-1:0]       req;
    logic [MASTERS*WIDTH-1:0] data_in;
    logic [MASTERS-1:0]       gnt;
    logic [IW-1:0]            bus_owner;
    logic                     bus_valid;
    logic [WIDTH-1:0]         data_out;

    modport master (
        output req,
        output data_in,
        input  gnt,
        input  bus_owner,
        input  bus_valid,
        input  data_out
    );

    modport slave (
        input  req,
        input  data_in,
        output gnt,
        output bus_owner,
        output bus_valid,
        output data_out
    );

endinterface

// File: rtl/bus_arbiter.sv
// Combinational winner selection: scans the eligible requesters (req with the
// excluded ones masked off) starting at start_ptr and wrapping around, and
// returns the first hit as one-hot plus its index.
module bus_arbiter #(
    parameter int MASTERS = 4,
    parameter int IW      = 2
) (
    input  logic [MASTERS-1:0] req,
    input  logic [MASTERS-1:0] excl,
    input  logic [IW-1:0]      start_ptr,
    output logic [MASTERS-1:0] win_onehot,
    output logic [IW-1:0]      win_idx,
    output logic               found
);

    logic [MASTERS-1:0] elig_s;
    logic [IW-1:0]      idx_s;
    int                 pos_s;

    // Rotating first-hit search over the eligible mask.
    always_comb begin
        elig_s     = req & ~excl;
        win_onehot = '0;
        win_idx    = '0;
        found      = 1'b0;
        idx_s      = '0;
        pos_s      = 0;
        for (int k = 0; k < MASTERS; k++) begin
            pos_s = int'(start_ptr) + k;
            if (pos_s >= MASTERS) begin
                pos_s = pos_s - MASTERS;
            end else begin
                pos_s = pos_s;
            end
            idx_s = IW'(pos_s);
            if (!found && elig_s[idx_s]) begin
                found             = 1'b1;
                win_onehot[idx_s] = 1'b1;
                win_idx           = idx_s;
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/multi_master_bus.sv
// Shared-bus controller: arbitrates up to MASTERS requesters onto one internal
// tri-state bus, limits bus tenure while others wait, and broadcasts the
// owner's word on a registered output with a valid flag.
module multi_master_bus
    import bus_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MASTERS  = 4,
    parameter int MODE     = 0,
    parameter int MAX_HOLD = 4
) (
    input logic             clk,
    input logic             rst,
    multi_master_bus_if.slave bus
);

    localparam int IW = idx_width(MASTERS);
    localparam int TW = idx_width(MAX_HOLD + 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [IW-1:0] LAST_IDX  = IW'(MASTERS - 1);

    bus_state_e         state_r, state_s;
    logic [MASTERS-1:0] gnt_r, gnt_s;
    logic [IW-1:0]      owner_r, owner_s;
    logic [TW-1:0]      tenure_r, tenure_s;
    logic [IW-1:0]      rr_ptr_r, rr_ptr_s;
    logic               bus_valid_r;
    logic [WIDTH-1:0]   data_out_r;

    logic [MASTERS-1:0] excl_s;
    logic [IW-1:0]      start_s;
    logic [MASTERS-1:0] win_oh_s;
    logic [IW-1:0]      win_idx_s;
    logic               win_found_s;
    logic               owner_req_s;
    logic               expired_s;
    logic               take_s;

    wire  [WIDTH-1:0]   bi_data_s;

    // Only the granted master drives the shared net; grant is one-hot so
    // there is never more than one active driver.
    for (genvar i = 0; i < MASTERS; i++) begin : g_drv
        assign bi_data_s = gnt_r[i] ? bus.data_in[i*WIDTH +: WIDTH] : {WIDTH{1'bz}};
    end

    // While busy the current owner is kept out of any re-arbitration; the
    // search origin is the round-robin pointer or index 0 for fixed priority.
    always_comb begin
        excl_s = '0;
        if (state_r == BUSY) begin
            excl_s[owner_r] = 1'b1;
        end else begin
            excl_s = '0;
        end
        if (MODE == ARB_RR) begin
            start_s = rr_ptr_r;
        end else begin
            start_s = '0;
        end
    end

    bus_arbiter #(
        .MASTERS (MASTERS),
        .IW      (IW)
    ) u_arb (
        .req        (bus.req),
        .excl       (excl_s),
        .start_ptr  (start_s),
        .win_onehot (win_oh_s),
        .win_idx    (win_idx_s),
        .found      (win_found_s)
    );

    // Next-state, next-grant and tenure/pointer bookkeeping.
    always_comb begin
        state_s     = state_r;
        gnt_s       = gnt_r;
        owner_s     = owner_r;
        tenure_s    = tenure_r;
        rr_ptr_s    = rr_ptr_r;
        take_s      = 1'b0;
        owner_req_s = bus.req[owner_r];
        expired_s   = (MAX_HOLD != 0) && (tenure_r == HOLD_LAST);

        case (state_r)
            IDLE: begin
                if (win_found_s) begin
                    take_s = 1'b1;
                end else begin
                    gnt_s = '0;
                end
            end
            BUSY: begin
                if (!owner_req_s) begin
                    if (win_found_s) begin
                        take_s = 1'b1;
                    end else begin
                        state_s  = IDLE;
                        gnt_s    = '0;
                        tenure_s = '0;
                    end
                end else if (expired_s && win_found_s) begin
                    take_s = 1'b1;
                end else begin
                    // Keep the owner; tenure saturates at its last value.
                    if ((MAX_HOLD != 0) && !expired_s) begin
                        tenure_s = tenure_r + TW'(1);
                    end else begin
                        tenure_s = tenure_r;
                    end
                end
            end
            default: begin
                state_s  = IDLE;
                gnt_s    = '0;
                tenure_s = '0;
            end
        endcase

        if (take_s) begin
            state_s  = BUSY;
            gnt_s    = win_oh_s;
            owner_s  = win_idx_s;
            tenure_s = '0;
            rr_ptr_s = (win_idx_s == LAST_IDX) ? '0 : (win_idx_s + IW'(1));
        end else begin
            rr_ptr_s = rr_ptr_r;
        end
    end

    // Arbitration state registers; reset drops the grant without a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= IDLE;
            gnt_r    <= '0;
            owner_r  <= '0;
            tenure_r <= '0;
            rr_ptr_r <= '0;
        end else begin
            state_r  <= state_s;
            gnt_r    <= gnt_s;
            owner_r  <= owner_s;
            tenure_r <= tenure_s;
            rr_ptr_r <= rr_ptr_s;
        end
    end

    // Output stage: capture the bus word while granted, hold it when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_valid_r <= 1'b0;
            data_out_r  <= '0;
        end else begin
            bus_valid_r <= |gnt_r;
            if (|gnt_r) begin
                data_out_r <= bi_data_s;
            end else begin
                data_out_r <= data_out_r;
            end
        end
    end

    assign bus.gnt       = gnt_r;
    assign bus.bus_owner = owner_r;
    assign bus.bus_valid = bus_valid_r;
    assign bus.data_out  = data_out_r;

endmodule

// File: tb/tb_multi_master_bus.sv
// Bench for multi_master_bus: two instances (fixed priority / MAX_HOLD=4 and
// round-robin / MAX_HOLD=1) share one stimulus stream and are compared every
// cycle against a behavioural model, plus directed checks of key scenarios.
module tb_multi_master_bus;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] din [4];

    int n_tests;
    int n_fail;

    // Model state per configuration (0 = fixed/hold 4, 1 = round-robin/hold 1).
    int         cfg_mode [2] = '{0, 1};
    int         cfg_hold [2] = '{4, 1};
    int         m_owner  [2];
    int         m_last   [2];
    int         m_held   [2];
    int         m_ptr    [2];
    logic       m_valid  [2];
    logic [7:0] m_data   [2];
    int         rr_seq   [5] = '{0, 1, 2, 3, 0};

    multi_master_bus_if #(.WIDTH(8), .MASTERS(4)) if_f ();
    multi_master_bus_if #(.WIDTH(8), .MASTERS(4)) if_r ();

    assign if_f.req     = req;
    assign if_f.data_in = {din[3], din[2], din[1], din[0]};
    assign if_r.req     = req;
    assign if_r.data_in = {din[3], din[2], din[1], din[0]};

    multi_master_bus #(.WIDTH(8), .MASTERS(4), .MODE(0), .MAX_HOLD(4)) u_fix (
        .clk (clk),
        .rst (rst),
        .bus (if_f)
    );

    multi_master_bus #(.WIDTH(8), .MASTERS(4), .MODE(1), .MAX_HOLD(1)) u_rr (
        .clk (clk),
        .rst (rst),
        .bus (if_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_owner[c] = -1;
            m_last[c]  = 0;
            m_held[c]  = 0;
            m_ptr[c]   = 0;
            m_valid[c] = 1'b0;
            m_data[c]  = 8'h00;
        end
    endtask

    // First requester (other than excl) found walking from the search origin.
    function automatic int pick(input int c, input int excl);
        int start;
        int i;
        start = (cfg_mode[c] == 1) ? m_ptr[c] : 0;
        for (int k = 0; k < 4; k++) begin
            i = (start + k) % 4;
            if (req[i[1:0]] && (i != excl)) return i;
        end
        return -1;
    endfunction

    task automatic grant(input int c, input int n);
        m_owner[c] = n;
        m_last[c]  = n;
        m_held[c]  = 1;
        m_ptr[c]   = (n + 1) % 4;
    endtask

    // One clock edge of the bus rules, evaluated on the pre-edge inputs.
    task automatic model_edge(input int c);
        logic       nv;
        logic [7:0] nd;
        int         o;
        int         n;
        o  = m_owner[c];
        nv = (o >= 0);
        nd = (o >= 0) ? din[o[1:0]] : m_data[c];
        if ((o < 0) || !req[o[1:0]]) begin
            n = pick(c, o);
            if (n >= 0) grant(c, n);
            else m_owner[c] = -1;
        end else if ((cfg_hold[c] > 0) && (m_held[c] >= cfg_hold[c]) && (pick(c, o) >= 0)) begin
            grant(c, pick(c, o));
        end else if (m_held[c] < 1000) begin
            m_held[c]++;
        end
        m_valid[c] = nv;
        m_data[c]  = nd;
    endtask

    task automatic check_all();
        logic [3:0] eg;
        for (int c = 0; c < 2; c++) begin
            eg = (m_owner[c] >= 0) ? (4'b0001 << m_owner[c]) : 4'b0000;
            chk($sformatf("cfg%0d_gnt", c), 32'((c == 0) ? if_f.gnt : if_r.gnt), 32'(eg));
            chk($sformatf("cfg%0d_owner", c), 32'((c == 0) ? if_f.bus_owner : if_r.bus_owner), 32'(m_last[c]));
            chk($sformatf("cfg%0d_valid", c), 32'((c == 0) ? if_f.bus_valid : if_r.bus_valid), 32'(m_valid[c]));
            chk($sformatf("cfg%0d_data", c), 32'((c == 0) ? if_f.data_out : if_r.data_out), 32'(m_data[c]));
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        check_all();
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b1;
        req     = 4'b1111;
        din[0]  = 8'h10;
        din[1]  = 8'h21;
        din[2]  = 8'h32;
        din[3]  = 8'h43;
        model_reset();

        // Reset holds everything quiet even with all masters requesting.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(if_f.gnt), 32'(4'b0000));
        chk("rst_valid", 32'(if_f.bus_valid), 32'(1'b0));
        chk("rst_data", 32'(if_f.data_out), 32'(8'h00));
        chk("rst_owner", 32'(if_f.bus_owner), 32'(2'd0));
        @(negedge clk);
        rst = 1'b0;

        step();
        chk("release_gnt", 32'(if_f.gnt), 32'(4'b0001));
        chk("rr_owner_0", 32'(if_r.bus_owner), 32'(rr_seq[0]));

        // Round-robin with one-cycle tenure rotates every edge.
        for (int k = 1; k < 5; k++) begin
            step();
            chk($sformatf("rr_owner_%0d", k), 32'(if_r.bus_owner), 32'(rr_seq[k]));
        end

        // Fixed priority: master 1 beats master 2, then hands over.
        req    = 4'b0110;
        din[1] = 8'hAA;
        din[2] = 8'h55;
        step();
        chk("fp_gnt1", 32'(if_f.gnt), 32'(4'b0010));
        step();
        chk("fp_data_aa", 32'(if_f.data_out), 32'(8'hAA));
        req = 4'b0100;
        step();
        chk("fp_gnt2", 32'(if_f.gnt), 32'(4'b0100));
        chk("fp_valid_a", 32'(if_f.bus_valid), 32'(1'b1));
        step();
        chk("fp_data_55", 32'(if_f.data_out), 32'(8'h55));
        chk("fp_valid_b", 32'(if_f.bus_valid), 32'(1'b1));

        // Asynchronous reset between edges clears outputs at once.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("areset_gnt", 32'(if_f.gnt), 32'(4'b0000));
        chk("areset_data", 32'(if_f.data_out), 32'(8'h00));
        chk("areset_valid", 32'(if_f.bus_valid), 32'(1'b0));
        model_reset();
        rst = 1'b0;

        // Tenure limit: master 0 owns four cycles, then master 3 takes over.
        req = 4'b0001;
        step();
        chk("ten_gnt_0", 32'(if_f.gnt), 32'(4'b0001));
        req = 4'b1001;
        for (int k = 1; k < 4; k++) begin
            step();
            chk($sformatf("ten_gnt_%0d", k), 32'(if_f.gnt), 32'(4'b0001));
        end
        step();
        chk("ten_handover", 32'(if_f.gnt), 32'(4'b1000));

        // Sole requester keeps the bus well past the tenure limit.
        req    = 4'b0001;
        din[0] = 8'hE5;
        for (int k = 0; k < 11; k++) begin
            step();
            chk($sformatf("keep_gnt_%0d", k), 32'(if_f.gnt), 32'(4'b0001));
        end

        // All requests drop: one trailing valid cycle, then idle holding E5.
        req = 4'b0000;
        step();
        chk("idle_gnt", 32'(if_f.gnt), 32'(4'b0000));
        chk("idle_trail", 32'(if_f.bus_valid), 32'(1'b1));
        din[0] = 8'h11;
        step();
        chk("idle_valid", 32'(if_f.bus_valid), 32'(1'b0));
        chk("idle_hold", 32'(if_f.data_out), 32'(8'hE5));

        // Randomized traffic against the model; requests change in bursts.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                req = 4'($urandom_range(0, 15));
            end
            for (int i = 0; i < 4; i++) begin
                din[i] = 8'($urandom);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
